// File: rtl/difference_reconstruction_pkg.sv
// ---------------------------------------------------------------------------
// difference_reconstruction_pkg
// Shared constants and types for the difference encoder/reconstruction pair.
// Both sides import this so they agree on the element count and data width.
//   NUM_ELEMS : number of list elements / differences (9)
//   DATA_W    : default element width (8)
//   CNT_W     : width of the unique-element count (4)
//   state_t   : reconstruction FSM states
// ---------------------------------------------------------------------------
package difference_reconstruction_pkg;

    localparam int NUM_ELEMS = 9;
    localparam int DATA_W    = 8;
    localparam int CNT_W     = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

endpackage : difference_reconstruction_pkg

// File: rtl/difference_reconstruction.sv
// ---------------------------------------------------------------------------
// difference_reconstruction
// Rebuilds a sorted, duplicate-free list from a base value and successive
// differences by running accumulation, one element per clock.
// Ports:
//   clk, rst_n       : clock (rising edge), asynchronous active-low reset
//   start            : decode request, sampled only while idle
//   in1..in9         : in1 = base, inK = out(K) - out(K-1)
//   unique_count     : number of valid elements N (0..9)
//   out1..out9       : reconstructed list, entries above N are zero
//   busy             : high while accumulating
//   done             : one-cycle pulse when the result is complete
//   err              : unique_count > 9 on the accepted start (sticky)
//   ovf              : an accumulation wrapped (sticky)
// ---------------------------------------------------------------------------
module difference_reconstruction
    import difference_reconstruction_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [W-1:0]     in1,
    input  logic [W-1:0]     in2,
    input  logic [W-1:0]     in3,
    input  logic [W-1:0]     in4,
    input  logic [W-1:0]     in5,
    input  logic [W-1:0]     in6,
    input  logic [W-1:0]     in7,
    input  logic [W-1:0]     in8,
    input  logic [W-1:0]     in9,
    input  logic [CNT_W-1:0] unique_count,
    output logic [W-1:0]     out1,
    output logic [W-1:0]     out2,
    output logic [W-1:0]     out3,
    output logic [W-1:0]     out4,
    output logic [W-1:0]     out5,
    output logic [W-1:0]     out6,
    output logic [W-1:0]     out7,
    output logic [W-1:0]     out8,
    output logic [W-1:0]     out9,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             ovf
);

    logic [W-1:0]     in_arr [NUM_ELEMS];

    state_t           state_q, state_d;
    logic [CNT_W-1:0] idx_q,   idx_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [W-1:0]     diff_q [NUM_ELEMS];
    logic [W-1:0]     diff_d [NUM_ELEMS];
    logic [W-1:0]     out_q  [NUM_ELEMS];
    logic [W-1:0]     out_d  [NUM_ELEMS];
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q,  err_d;
    logic             ovf_q,  ovf_d;

    logic [W-1:0]     prev_val;
    logic [W-1:0]     cur_diff;
    logic [W:0]       sum;

    assign in_arr[0] = in1;
    assign in_arr[1] = in2;
    assign in_arr[2] = in3;
    assign in_arr[3] = in4;
    assign in_arr[4] = in5;
    assign in_arr[5] = in6;
    assign in_arr[6] = in7;
    assign in_arr[7] = in8;
    assign in_arr[8] = in9;

    // Single shared adder: element idx is the previous element plus the
    // idx-th difference. For idx == 1 the previous value is taken as zero so
    // the base passes straight through and can never carry.
    always_comb begin
        prev_val = '0;
        cur_diff = '0;
        for (int k = 0; k < NUM_ELEMS; k++) begin
            if (idx_q == CNT_W'(k + 1)) begin
                cur_diff = diff_q[k];
            end
        end
        for (int k = 1; k < NUM_ELEMS; k++) begin
            if (idx_q == CNT_W'(k + 1)) begin
                prev_val = out_q[k-1];
            end
        end
        sum = {1'b0, prev_val} + {1'b0, cur_diff};
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        out_d   = out_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    diff_d = in_arr;
                    cnt_d  = unique_count;
                    out_d  = '{default: '0};
                    err_d  = 1'b0;
                    ovf_d  = 1'b0;
                    idx_d  = CNT_W'(1);
                    if (unique_count == '0) begin
                        done_d = 1'b1;
                    end else if (unique_count > CNT_W'(NUM_ELEMS)) begin
                        err_d  = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        state_d = ACCUM;
                        busy_d  = 1'b1;
                    end
                end
            end
            ACCUM: begin
                for (int k = 0; k < NUM_ELEMS; k++) begin
                    if (idx_q == CNT_W'(k + 1)) begin
                        out_d[k] = sum[W-1:0];
                    end
                end
                if (sum[W]) begin
                    ovf_d = 1'b1;
                end
                if (idx_q == cnt_q) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    idx_d = idx_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            diff_q  <= '{default: '0};
            out_q   <= '{default: '0};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out1 = out_q[0];
    assign out2 = out_q[1];
    assign out3 = out_q[2];
    assign out4 = out_q[3];
    assign out5 = out_q[4];
    assign out6 = out_q[5];
    assign out7 = out_q[6];
    assign out8 = out_q[7];
    assign out9 = out_q[8];
    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;
    assign ovf  = ovf_q;

endmodule : difference_reconstruction
